// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle for the sequential restoring divider.
// The caller drives operands and start; the divider returns the status and registered results.
interface seq_restoring_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider. Each iteration does one N+1-bit trial
// subtraction and produces one quotient bit, so a divide takes N iterations.
//
// state | meaning
// IDLE  | waiting for start, results holding
// RUN   | one iteration per clock
// DONE  | results valid this cycle, done pulses; a new start is accepted here
module seq_restoring_divider #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N:0]    rem_acc;
    logic [N-1:0]  quo_acc;
    logic [N-1:0]  div_reg;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          zero_div;
    logic          last_iter;
    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic          trial_neg;
    logic [N:0]    rem_new;
    logic [N-1:0]  quo_new;

    assign accept    = bus.start && (state != RUN);
    assign zero_div  = (bus.divisor == '0);
    assign last_iter = (cnt == CW'(N - 1));

    // Trial subtraction as a + ~b + 1; the MSB of the N+1-bit result is the borrow sign.
    always_comb begin
        shifted   = {rem_acc[N-1:0], quo_acc[N-1]};
        trial     = shifted + ~{1'b0, div_reg} + {{N{1'b0}}, 1'b1};
        trial_neg = trial[N];
        rem_new   = trial_neg ? shifted : trial;
        quo_new   = {quo_acc[N-2:0], ~trial_neg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = zero_div ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // Published results only change on completion, so they hold through a following operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_acc         <= '0;
            quo_acc         <= '0;
            div_reg         <= '0;
            cnt             <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (accept) begin
            if (zero_div) begin
                bus.quotient    <= '1;
                bus.remainder   <= bus.dividend;
                bus.div_by_zero <= 1'b1;
            end else begin
                rem_acc <= '0;
                quo_acc <= bus.dividend;
                div_reg <= bus.divisor;
                cnt     <= '0;
            end
        end else if (state == RUN) begin
            rem_acc <= rem_new;
            quo_acc <= quo_new;
            cnt     <= cnt + CW'(1);
            if (last_iter) begin
                bus.quotient    <= quo_new;
                bus.remainder   <= rem_new[N-1:0];
                bus.div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed handshake scenarios with literal
// expectations plus a randomized stream compared cycle by cycle against an arithmetic model.
module tb_seq_restoring_divider;
    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    int   cyc;
    int   c0;
    int   lat;

    seq_restoring_divider_if #(.N(N)) bus ();

    seq_restoring_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Reference model: a divide is a countdown of N busy cycles, results come from / and %.
    int         m_left;
    bit         m_done;
    logic [7:0] m_q, m_r, m_a, m_d;
    bit         m_dz;
    logic [7:0] p_q, p_r, p_a, p_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 0; m_q = 0; m_r = 0; m_dz = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1; m_q = p_q; m_r = p_r; m_dz = 0; m_a = p_a; m_d = p_d;
                end
            end else if (bus.start) begin
                if (bus.divisor == 0) begin
                    m_done = 1; m_q = 8'hff; m_r = bus.dividend; m_dz = 1;
                end else begin
                    m_left = N;
                    p_q = bus.dividend / bus.divisor;
                    p_r = bus.dividend % bus.divisor;
                    p_a = bus.dividend;
                    p_d = bus.divisor;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cycle{busy,done,dz,q,r}",
            {13'd0, bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder},
            {13'd0, m_left > 0, m_done, m_dz, m_q, m_r});
        if (bus.done && !bus.div_by_zero && m_d != 0)
            chk("invariant", {31'd0, (32'(bus.quotient) * 32'(m_d) + 32'(bus.remainder) == 32'(m_a))
                              && (bus.remainder < m_d)}, 32'd1);
    end

    task automatic start_now(input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        c0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        start_now(a, b);
    endtask

    task automatic wait_done();
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.done) found = 1;
        end
        if (!found) chk("done_timeout", 32'd0, 32'd1);
        lat = cyc - c0 + 1;
    endtask

    task automatic chk_result(input string tag, input int exp_lat, input logic [7:0] q,
                              input logic [7:0] r, input bit dz);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_q"}, bus.quotient, q);
        chk({tag, "_r"}, bus.remainder, r);
        chk({tag, "_dz"}, bus.div_by_zero, dz);
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; cyc = 0; c0 = 0; lat = 0;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}, 0);
        rst_n = 1'b1;

        start_op(8'd100, 8'd7);
        wait_done();
        chk_result("d100_7", N + 1, 8'd14, 8'd2, 1'b0);

        start_op(8'd255, 8'd1);
        wait_done();
        chk_result("d255_1", N + 1, 8'd255, 8'd0, 1'b0);
        start_now(8'd5, 8'd9);
        wait_done();
        chk_result("b2b_5_9", N + 1, 8'd0, 8'd5, 1'b0);

        start_op(8'd200, 8'd0);
        wait_done();
        chk_result("dz200", 1, 8'd255, 8'd200, 1'b1);
        start_op(8'd9, 8'd3);
        wait_done();
        chk_result("d9_3", N + 1, 8'd3, 8'd0, 1'b0);

        start_op(8'd77, 8'd5);
        repeat (2) @(posedge clk);
        #1 bus.start = 1'b1; bus.dividend = 8'd10; bus.divisor = 8'd2;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done();
        chk_result("ignore_start", N + 1, 8'd15, 8'd2, 1'b0);

        start_op(8'd100, 8'd7);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", bus.done, 0);
        end
        start_op(8'd50, 8'd6);
        wait_done();
        chk_result("d50_6", N + 1, 8'd8, 8'd2, 1'b0);

        for (int i = 0; i < 30000; i++) begin
            @(posedge clk); #1;
            bus.start    = ($urandom_range(3) != 0);
            bus.dividend = 8'($urandom);
            case ($urandom_range(15))
                0:       bus.divisor = 8'd0;
                1, 2:    bus.divisor = 8'($urandom_range(1, 3));
                default: bus.divisor = 8'($urandom_range(1, 255));
            endcase
        end
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
